// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage types: FSM encoding, bus widths and the buffered instruction record.
package fetch_ctrl_pkg;
  localparam int ADDR_W = 16;
  localparam int INST_W = 16;
  localparam logic [ADDR_W-1:0] RESET_ADDR_DEF = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } inst_entry_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage signal bundle: instruction memory port, redirect/halt control and decode handshake.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              halt;
  logic              inst_valid;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_addr, halt, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_addr, halt, inst_ready
  );
endinterface

// File: rtl/fetch_ctrl_inst_fifo.sv
// Small registered instruction FIFO; head is read straight from storage (no write bypass).
module inst_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             full, do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  // a full buffer may still take a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign valid = (count != '0);
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem read, redirect with single pending drop.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_ADDR = RESET_ADDR_DEF,
  parameter int                DEPTH      = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_ctrl_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt, req_addr;
  logic              drop, drop_nxt;
  logic              grant, rsp, push, pop;
  logic [CW-1:0]     count, count_after;
  inst_entry_t       wr_entry, head;

  assign grant       = (state == ST_REQ) && bus.imem_gnt;
  assign rsp         = (state == ST_WAIT) && bus.imem_rvalid;
  assign push        = rsp && !drop && !bus.redirect;
  assign pop         = bus.inst_valid && bus.inst_ready;
  assign count_after = bus.redirect ? '0 : count + CW'(push) - CW'(pop);

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    drop_nxt     = drop;
    case (state)
      ST_IDLE: if (!bus.halt && count < CW'(DEPTH)) state_nxt = ST_REQ;
      ST_REQ:  if (bus.imem_gnt) state_nxt = ST_WAIT;
      ST_WAIT: if (bus.imem_rvalid)
                 state_nxt = (!bus.halt && count_after < CW'(DEPTH)) ? ST_REQ : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // a dropped request's grant must not move the pc off the redirect target
    if (bus.redirect)        fetch_pc_nxt = bus.redirect_addr;
    else if (grant && !drop) fetch_pc_nxt = fetch_pc + 16'd1;
    if (bus.redirect && (state == ST_REQ || (state == ST_WAIT && !bus.imem_rvalid)))
      drop_nxt = 1'b1;
    else if (rsp)
      drop_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_ADDR;
      req_addr <= RESET_ADDR;
      drop     <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      drop     <= drop_nxt;
      // address is latched on REQ entry so a redirect cannot disturb a pending request
      if (state_nxt == ST_REQ && state != ST_REQ) req_addr <= fetch_pc_nxt;
    end
  end

  assign wr_entry = '{data: bus.imem_rdata, pc: req_addr};

  inst_fifo #(.WIDTH($bits(inst_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .din   (wr_entry),
    .dout  (head),
    .valid (bus.inst_valid),
    .count (count)
  );

  assign bus.imem_req  = (state == ST_REQ);
  assign bus.imem_addr = req_addr;
  assign bus.inst_data = head.data;
  assign bus.inst_pc   = head.pc;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Random/directed bench for fetch_ctrl with a transaction-level memory and instruction-stream model.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [15:0] RADDR = 16'h0000;

  logic clk = 1'b0;
  logic reset;
  fetch_ctrl_if bus();

  fetch_ctrl #(.RESET_ADDR(RADDR), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    bit          stale;
    int          dly;
  } rsp_t;

  rsp_t        mq[$];
  logic [15:0] pop_pc[$];
  int          pop_t[$];
  int          n_cmp = 0, n_bad = 0;
  int          occ, cyc_n, n_gnt;
  int          gnt_pct, lat_lo, lat_hi, rdy_pct;
  bit          halt_v, force_rv, req_stale;
  bit          prev_req, prev_gnt, prev_halt;
  logic [15:0] prev_addr, exp_pc, last_gnt_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] data_of(input logic [15:0] a);
    logic [15:0] m;
    m = a * 16'h9E37;
    return m ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] qget(input logic [15:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 16'hxxxx;
  endfunction

  task automatic do_reset(input int hold);
    reset = 1'b1;
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
    bus.redirect = 0; bus.redirect_addr = 0; bus.halt = 0; bus.inst_ready = 0;
    mq.delete(); pop_pc.delete(); pop_t.delete();
    occ = 0; exp_pc = RADDR; req_stale = 0; cyc_n = 0; n_gnt = 0;
    prev_req = 0; prev_gnt = 0; prev_halt = 0; prev_addr = RADDR;
    halt_v = 0; force_rv = 0; last_gnt_addr = 16'hxxxx;
    repeat (hold) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"},  bus.imem_req, 0);
    chk({tag, "_addr"}, bus.imem_addr, RADDR);
    chk({tag, "_vld"},  bus.inst_valid, 0);
    chk({tag, "_data"}, bus.inst_data, 0);
    chk({tag, "_pc"},   bus.inst_pc, 0);
  endtask

  // One clock cycle, called at a falling edge: check outputs, choose inputs, advance the model.
  task automatic cyc(input bit redir, input logic [15:0] raddr);
    bit req, gnt, rv, acc, pop, rdy;
    logic [15:0] rdat;
    rsp_t e;
    req = bus.imem_req;
    chk("inst_valid", bus.inst_valid, occ > 0);
    if (prev_req && !prev_gnt) begin
      chk("req_hold", req, 1);
      chk("addr_hold", bus.imem_addr, prev_addr);
    end
    if (req && !prev_req) chk("halt_gate", prev_halt, 0);
    rdy = ($urandom_range(1, 100) <= rdy_pct);
    pop = (occ > 0) && rdy;
    if (pop) begin
      chk("inst_pc", bus.inst_pc, exp_pc);
      chk("inst_data", bus.inst_data, data_of(exp_pc));
      pop_pc.push_back(bus.inst_pc);
      pop_t.push_back(cyc_n);
      exp_pc = exp_pc + 16'd1;
    end
    if (redir) begin
      foreach (mq[i]) mq[i].stale = 1;
      if (req) req_stale = 1;
    end
    rv = 0; acc = 0; rdat = 16'($urandom);
    if (mq.size() > 0) begin
      if (mq[0].dly == 0) begin
        e = mq.pop_front();
        rv = 1; acc = !e.stale; rdat = data_of(e.addr);
      end else mq[0].dly = mq[0].dly - 1;
    end else if (force_rv) begin
      rv = 1; rdat = 16'hDEAD;
    end
    gnt = req && ($urandom_range(1, 100) <= gnt_pct);
    if (gnt) begin
      mq.push_back('{bus.imem_addr, req_stale, int'($urandom_range(lat_lo, lat_hi))});
      req_stale = 0; n_gnt++; last_gnt_addr = bus.imem_addr;
    end
    if (redir) begin
      occ = 0; exp_pc = raddr;
    end else begin
      occ = occ + int'(acc) - int'(pop);
      if (acc) chk("occ_bound", occ <= DEPTH, 1);
    end
    bus.imem_gnt = gnt; bus.imem_rvalid = rv; bus.imem_rdata = rdat;
    bus.redirect = redir; bus.redirect_addr = raddr;
    bus.inst_ready = rdy; bus.halt = halt_v;
    prev_req = req; prev_gnt = gnt; prev_addr = bus.imem_addr; prev_halt = halt_v;
    cyc_n++;
    @(negedge clk);
  endtask

  initial begin
    int g, p;
    bit found;

    // streaming fetch, immediate grant, 1-cycle read latency
    gnt_pct = 100; lat_lo = 0; lat_hi = 0; rdy_pct = 100;
    do_reset(3);
    chk_reset_outs("reset");
    cyc(0, 0);
    chk("first_req", bus.imem_req, 1);
    repeat (10) cyc(0, 0);
    chk("stream_pops", pop_pc.size() >= 4, 1);
    for (int i = 0; i < 4; i++) chk("stream_pc", qget(pop_pc, i), 16'(i));
    if (pop_t.size() >= 4) begin
      chk("first_pop_t", pop_t[0], 3);
      for (int i = 1; i < 4; i++) chk("pop_gap", pop_t[i] - pop_t[i-1], 2);
    end

    // decode stalled: buffer fills to DEPTH and fetching stops
    do_reset(2);
    rdy_pct = 0;
    repeat (20) cyc(0, 0);
    chk("stall_gnts", n_gnt, DEPTH);
    chk("stall_req", bus.imem_req, 0);
    chk("stall_vld", bus.inst_valid, 1);
    rdy_pct = 100;
    repeat (4) cyc(0, 0);
    chk("stall_pc0", qget(pop_pc, 0), 16'h0000);
    chk("stall_pc1", qget(pop_pc, 1), 16'h0001);

    // redirect while waiting on pc 5
    do_reset(2);
    lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 100 && last_gnt_addr !== 16'h0005; i++) cyc(0, 0);
    chk("reach_pc5", last_gnt_addr, 16'h0005);
    cyc(1, 16'h0040);
    pop_pc.delete();
    chk("flush_vld", bus.inst_valid, 0);
    repeat (15) cyc(0, 0);
    chk("redir_pc0", qget(pop_pc, 0), 16'h0040);
    chk("redir_pc1", qget(pop_pc, 1), 16'h0041);

    // redirect coincident with a response and with a pop
    do_reset(2);
    lat_lo = 0; lat_hi = 0; rdy_pct = 30; found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (mq.size() > 0 && mq[0].dly == 0 && occ > 0) found = 1;
      else cyc(0, 0);
    end
    chk("coinc_found", found, 1);
    rdy_pct = 100;
    cyc(1, 16'h1234);
    pop_pc.delete();
    chk("coinc_flush", bus.inst_valid, 0);
    repeat (10) cyc(0, 0);
    chk("coinc_pc", qget(pop_pc, 0), 16'h1234);

    // address wrap
    do_reset(2);
    cyc(1, 16'hFFFF);
    repeat (12) cyc(0, 0);
    chk("wrap_pc0", qget(pop_pc, 0), 16'hFFFF);
    chk("wrap_pc1", qget(pop_pc, 1), 16'h0000);
    chk("wrap_pc2", qget(pop_pc, 2), 16'h0001);

    // halt while a read is outstanding
    do_reset(2);
    lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 20 && n_gnt == 0; i++) cyc(0, 0);
    chk("halt_setup", n_gnt, 1);
    halt_v = 1; g = n_gnt; p = pop_pc.size();
    repeat (12) cyc(0, 0);
    chk("halt_gnts", n_gnt - g, 0);
    chk("halt_buffered", pop_pc.size() - p, 1);
    chk("halt_req", bus.imem_req, 0);
    halt_v = 0;
    cyc(0, 0);
    chk("halt_resume", bus.imem_req, 1);

    // reset in the middle of a read, then a stray rvalid just after release
    do_reset(2);
    lat_lo = 3; lat_hi = 3; rdy_pct = 0; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (occ > 0 && mq.size() > 0) found = 1;
      else cyc(0, 0);
    end
    chk("midwait_found", found, 1);
    reset = 1'b1;
    #1;
    chk_reset_outs("midwait");
    do_reset(2);
    lat_lo = 0; lat_hi = 0; rdy_pct = 100; force_rv = 1;
    cyc(0, 0);
    force_rv = 0;
    chk("late_rv_ignored", bus.inst_valid, 0);
    repeat (10) cyc(0, 0);
    chk("post_reset_pc", qget(pop_pc, 0), RADDR);

    // randomized traffic with redirects and halt toggling
    for (int ph = 0; ph < 4; ph++) begin
      gnt_pct = $urandom_range(30, 100);
      lat_lo = 0; lat_hi = $urandom_range(0, 3);
      rdy_pct = $urandom_range(20, 100);
      do_reset(2);
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 99) < 4) halt_v = !halt_v;
        if ($urandom_range(0, 99) < 3)
          cyc(1, ($urandom_range(0, 1) == 1) ? 16'hFFFE + 16'($urandom_range(0, 3))
                                             : 16'($urandom));
        else cyc(0, 0);
      end
      halt_v = 0; rdy_pct = 100; gnt_pct = 100;
      p = pop_pc.size();
      repeat (30) cyc(0, 0);
      chk("drain_live", pop_pc.size() > p, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
